// File: rtl/fetch_sequencer.sv
// Instruction fetch and PC-control sequencer: fetches over req/ack, issues over valid/ready,
// then strobes the program counter's load/offset/hold controls to step, branch or jump.
module fetch_sequencer #(
    parameter int          ADDR_WIDTH   = 16,
    parameter int          DATA_WIDTH   = 16,
    parameter int          OFFSET_WIDTH = 9,
    parameter logic [3:0]  BR_OPCODE    = 4'hC,
    parameter logic [3:0]  JMP_OPCODE   = 4'hD,
    parameter logic [3:0]  HALT_OPCODE  = 4'hF
) (
    input  logic                    clock_i,
    input  logic                    reset_i,
    input  logic [ADDR_WIDTH-1:0]   pc_value_i,
    output logic [ADDR_WIDTH-1:0]   load_value_o,
    output logic                    load_enable_o,
    output logic [OFFSET_WIDTH-1:0] offset_o,
    output logic                    offset_enable_o,
    output logic                    pc_hold_o,
    output logic                    mem_req_o,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    input  logic                    mem_ack_i,
    input  logic [DATA_WIDTH-1:0]   mem_data_i,
    output logic                    instr_valid_o,
    output logic [DATA_WIDTH-1:0]   instr_o,
    input  logic                    instr_ready_i,
    input  logic                    flag_i,
    input  logic [ADDR_WIDTH-1:0]   jump_target_i
);

    // state   | meaning
    // IDLE    | one settling cycle after reset
    // FETCH   | request outstanding at the current PC, waiting for ack
    // ISSUE   | instruction offered to decode, waiting for ready
    // ADVANCE | PC released for one cycle with the chosen update
    // HALTED  | halt accepted, parked until reset
    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_ADVANCE,
        S_HALTED
    } state_t;

    state_t                  state_q;
    logic [DATA_WIDTH-1:0]   instr_q;
    logic [ADDR_WIDTH-1:0]   load_value_q;
    logic [OFFSET_WIDTH-1:0] offset_q;
    logic                    load_enable_q;
    logic                    offset_enable_q;
    logic                    pc_hold_q;
    logic                    mem_req_q;
    logic                    instr_valid_q;
    logic [3:0]              opcode;

    assign opcode = instr_q[DATA_WIDTH-1 -: 4];

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q         <= S_IDLE;
            instr_q         <= '0;
            load_value_q    <= '0;
            offset_q        <= '0;
            load_enable_q   <= 1'b0;
            offset_enable_q <= 1'b0;
            pc_hold_q       <= 1'b1;
            mem_req_q       <= 1'b0;
            instr_valid_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_q   <= S_FETCH;
                    mem_req_q <= 1'b1;
                end
                S_FETCH: begin
                    if (mem_ack_i) begin
                        instr_q       <= mem_data_i;
                        mem_req_q     <= 1'b0;
                        instr_valid_q <= 1'b1;
                        state_q       <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (instr_ready_i) begin
                        instr_valid_q <= 1'b0;
                        if (opcode == HALT_OPCODE) begin
                            state_q <= S_HALTED;
                        end else begin
                            state_q   <= S_ADVANCE;
                            pc_hold_q <= 1'b0;
                            // Not-taken branches and all other opcodes leave both strobes low: PC steps by one.
                            if (opcode == BR_OPCODE && flag_i) begin
                                offset_enable_q <= 1'b1;
                                offset_q        <= instr_q[OFFSET_WIDTH-1:0];
                            end else if (opcode == JMP_OPCODE) begin
                                load_enable_q <= 1'b1;
                                load_value_q  <= jump_target_i;
                            end
                        end
                    end
                end
                S_ADVANCE: begin
                    pc_hold_q       <= 1'b1;
                    load_enable_q   <= 1'b0;
                    offset_enable_q <= 1'b0;
                    mem_req_q       <= 1'b1;
                    state_q         <= S_FETCH;
                end
                S_HALTED: begin
                    state_q <= S_HALTED;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign load_value_o    = load_value_q;
    assign load_enable_o   = load_enable_q;
    assign offset_o        = offset_q;
    assign offset_enable_o = offset_enable_q;
    assign pc_hold_o       = pc_hold_q;
    assign mem_req_o       = mem_req_q;
    assign mem_addr_o      = pc_value_i;
    assign instr_valid_o   = instr_valid_q;
    assign instr_o         = instr_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a small external program-counter model.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] pc;
    logic [15:0] load_value;
    logic        load_en;
    logic [8:0]  offset;
    logic        off_en;
    logic        pc_hold;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_data;
    logic        valid;
    logic [15:0] instr;
    logic        ready;
    logic        flag;
    logic [15:0] jt;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    fetch_sequencer dut (
        .clock_i        (clk),
        .reset_i        (reset),
        .pc_value_i     (pc),
        .load_value_o   (load_value),
        .load_enable_o  (load_en),
        .offset_o       (offset),
        .offset_enable_o(off_en),
        .pc_hold_o      (pc_hold),
        .mem_req_o      (mem_req),
        .mem_addr_o     (mem_addr),
        .mem_ack_i      (mem_ack),
        .mem_data_i     (mem_data),
        .instr_valid_o  (valid),
        .instr_o        (instr),
        .instr_ready_i  (ready),
        .flag_i         (flag),
        .jump_target_i  (jt)
    );

    // External PC: load, sign-extended offset add, or increment whenever released.
    always @(posedge clk) begin
        if (reset)
            pc <= 16'h0000;
        else if (pc_hold === 1'b0) begin
            if (load_en)
                pc <= load_value;
            else if (off_en)
                pc <= pc + {{7{offset[8]}}, offset};
            else
                pc <= pc + 16'h0001;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (mem_req === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        tests_run++;
        if ({mem_req, pc_hold, valid, load_en, off_en} !== 5'b01000) begin
            $display("FAIL reset_ctrl: got %b expected 01000", {mem_req, pc_hold, valid, load_en, off_en});
            tests_failed++;
        end
        tests_run++;
        if ({instr, load_value, offset} !== 41'd0) begin
            $display("FAIL reset_regs: got instr=%h lv=%h off=%h expected zeros", instr, load_value, offset);
            tests_failed++;
        end
        reset = 1'b0;
        tick();
        tests_run++;
        if ({mem_req, pc_hold, mem_addr} !== {2'b11, 16'h0000}) begin
            $display("FAIL reset_release: got req=%b hold=%b addr=%h expected 1 1 0000", mem_req, pc_hold, mem_addr);
            tests_failed++;
        end
    endtask

    task automatic test_alu_step();
        ready = 1'b1;
        tick();
        tick();
        tests_run++;
        if ({mem_req, valid} !== 2'b10) begin
            $display("FAIL alu_wait: got req=%b valid=%b expected 1 0", mem_req, valid);
            tests_failed++;
        end
        mem_ack  = 1'b1;
        mem_data = 16'h1234;
        tick();
        mem_ack = 1'b0;
        tests_run++;
        if ({valid, mem_req, instr} !== {2'b10, 16'h1234}) begin
            $display("FAIL alu_issue: got valid=%b req=%b instr=%h expected 1 0 1234", valid, mem_req, instr);
            tests_failed++;
        end
        tick();
        tests_run++;
        if ({pc_hold, load_en, off_en, valid} !== 4'b0000) begin
            $display("FAIL alu_advance: got %b expected 0000", {pc_hold, load_en, off_en, valid});
            tests_failed++;
        end
        tick();
        tests_run++;
        if ({mem_req, pc_hold, mem_addr} !== {2'b11, 16'h0001}) begin
            $display("FAIL alu_refetch: got req=%b hold=%b addr=%h expected 1 1 0001", mem_req, pc_hold, mem_addr);
            tests_failed++;
        end
    endtask

    task automatic test_taken_branch();
        bit ok;
        wait_req(ok);
        tests_run++;
        if (!ok) begin
            $display("FAIL br_req_timeout: got no request expected request");
            tests_failed++;
        end
        flag     = 1'b1;
        mem_ack  = 1'b1;
        mem_data = 16'hC1FC;
        tick();
        mem_ack = 1'b0;
        tests_run++;
        if ({valid, instr} !== {1'b1, 16'hC1FC}) begin
            $display("FAIL br_issue: got valid=%b instr=%h expected 1 c1fc", valid, instr);
            tests_failed++;
        end
        tick();
        flag = 1'b0;
        tests_run++;
        if ({pc_hold, off_en, load_en, offset} !== {3'b010, 9'h1FC}) begin
            $display("FAIL br_taken: got hold=%b oe=%b le=%b off=%h expected 0 1 0 1fc", pc_hold, off_en, load_en, offset);
            tests_failed++;
        end
        tick();
        tests_run++;
        if ({mem_req, off_en, mem_addr} !== {2'b10, 16'hFFFD}) begin
            $display("FAIL br_target: got req=%b oe=%b addr=%h expected 1 0 fffd", mem_req, off_en, mem_addr);
            tests_failed++;
        end
    endtask

    task automatic test_not_taken();
        flag     = 1'b0;
        mem_ack  = 1'b1;
        mem_data = 16'hC1FC;
        tick();
        mem_ack = 1'b0;
        tick();
        tests_run++;
        if ({pc_hold, off_en, load_en} !== 3'b000) begin
            $display("FAIL nt_advance: got %b expected 000", {pc_hold, off_en, load_en});
            tests_failed++;
        end
        tick();
        tests_run++;
        if ({pc_hold, mem_req, mem_addr} !== {2'b11, 16'hFFFE}) begin
            $display("FAIL nt_step: got hold=%b req=%b addr=%h expected 1 1 fffe", pc_hold, mem_req, mem_addr);
            tests_failed++;
        end
    endtask

    task automatic test_jump();
        jt       = 16'hBEEF;
        mem_ack  = 1'b1;
        mem_data = 16'hD000;
        tick();
        mem_ack = 1'b0;
        tick();
        tests_run++;
        if ({pc_hold, load_en, off_en, load_value} !== {3'b010, 16'hBEEF}) begin
            $display("FAIL jmp_advance: got hold=%b le=%b oe=%b lv=%h expected 0 1 0 beef", pc_hold, load_en, off_en, load_value);
            tests_failed++;
        end
        jt = 16'h0000;
        tick();
        tests_run++;
        if ({mem_req, load_en, mem_addr} !== {2'b10, 16'hBEEF}) begin
            $display("FAIL jmp_target: got req=%b le=%b addr=%h expected 1 0 beef", mem_req, load_en, mem_addr);
            tests_failed++;
        end
    endtask

    task automatic test_backpressure();
        ready    = 1'b0;
        mem_ack  = 1'b1;
        mem_data = 16'h5A5A;
        tick();
        mem_data = 16'hFFFF;
        for (int i = 0; i < 5; i++) begin
            tests_run++;
            if ({valid, mem_req, pc_hold, instr} !== {3'b101, 16'h5A5A}) begin
                $display("FAIL bp_hold[%0d]: got valid=%b req=%b hold=%b instr=%h expected 1 0 1 5a5a",
                         i, valid, mem_req, pc_hold, instr);
                tests_failed++;
            end
            tick();
        end
        mem_ack = 1'b0;
        ready   = 1'b1;
        tests_run++;
        if ({valid, pc_hold, instr} !== {2'b11, 16'h5A5A}) begin
            $display("FAIL bp_still: got valid=%b hold=%b instr=%h expected 1 1 5a5a", valid, pc_hold, instr);
            tests_failed++;
        end
        tick();
        tests_run++;
        if ({valid, pc_hold} !== 2'b00) begin
            $display("FAIL bp_accept: got valid=%b hold=%b expected 0 0", valid, pc_hold);
            tests_failed++;
        end
        tick();
        tests_run++;
        if ({mem_req, mem_addr} !== {1'b1, 16'hBEF0}) begin
            $display("FAIL bp_refetch: got req=%b addr=%h expected 1 bef0", mem_req, mem_addr);
            tests_failed++;
        end
    endtask

    task automatic test_reset_mid_fetch();
        reset = 1'b1;
        tick();
        tests_run++;
        if ({mem_req, pc_hold, valid} !== 3'b010) begin
            $display("FAIL rmf_reset: got %b expected 010", {mem_req, pc_hold, valid});
            tests_failed++;
        end
        reset    = 1'b0;
        mem_ack  = 1'b1;
        mem_data = 16'hF000;
        tick();
        mem_ack = 1'b0;
        tests_run++;
        if ({mem_req, valid, instr} !== {2'b10, 16'h0000}) begin
            $display("FAIL rmf_ack_dropped: got req=%b valid=%b instr=%h expected 1 0 0000", mem_req, valid, instr);
            tests_failed++;
        end
        tick();
        tests_run++;
        if ({mem_req, valid, mem_addr} !== {2'b10, 16'h0000}) begin
            $display("FAIL rmf_fetch: got req=%b valid=%b addr=%h expected 1 0 0000", mem_req, valid, mem_addr);
            tests_failed++;
        end
    endtask

    task automatic test_halt();
        int bad;
        ready    = 1'b1;
        mem_ack  = 1'b1;
        mem_data = 16'hF000;
        tick();
        mem_ack = 1'b0;
        tick();
        tests_run++;
        if ({valid, pc_hold, mem_req, load_en, off_en} !== 5'b01000) begin
            $display("FAIL halt_enter: got %b expected 01000", {valid, pc_hold, mem_req, load_en, off_en});
            tests_failed++;
        end
        bad     = 0;
        mem_ack = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (mem_req !== 1'b0 || pc_hold !== 1'b1 || valid !== 1'b0) bad++;
        end
        mem_ack = 1'b0;
        tests_run++;
        if (bad !== 0) begin
            $display("FAIL halt_stay: got %0d bad cycles expected 0", bad);
            tests_failed++;
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        tests_run++;
        if ({mem_req, pc_hold} !== 2'b11) begin
            $display("FAIL halt_exit: got req=%b hold=%b expected 1 1", mem_req, pc_hold);
            tests_failed++;
        end
    endtask

    task automatic test_reset_priority();
        ready    = 1'b1;
        jt       = 16'h1111;
        mem_ack  = 1'b1;
        mem_data = 16'hD000;
        tick();
        mem_ack = 1'b0;
        reset   = 1'b1;
        tick();
        tests_run++;
        if ({pc_hold, load_en, valid, load_value} !== {3'b100, 16'h0000}) begin
            $display("FAIL rp_handshake: got hold=%b le=%b valid=%b lv=%h expected 1 0 0 0000", pc_hold, load_en, valid, load_value);
            tests_failed++;
        end
        reset = 1'b0;
        tick();
    endtask

    initial begin
        reset    = 1'b1;
        mem_ack  = 1'b0;
        mem_data = 16'h0000;
        ready    = 1'b0;
        flag     = 1'b0;
        jt       = 16'h0000;
        #1;
        test_reset();
        test_alu_step();
        test_taken_branch();
        test_not_taken();
        test_jump();
        test_backpressure();
        test_reset_mid_fetch();
        test_halt();
        test_reset_priority();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Instruction-fetch and PC-control sequencer for the highRISC core. It reads the current program counter value and fetches the instruction from instruction memory over a req/ack handshake. It presents the instruction to decode over a valid/ready handshake. It then drives the program counter's control inputs (LoadValue/LoadEnable, Offset/OffsetEnable, PcHold) to step, branch or jump.

Parameters:
ADDR_WIDTH, 16, PC/memory address width
DATA_WIDTH, 16, instruction width
OFFSET_WIDTH, 9, signed branch offset width (Instr[OFFSET_WIDTH-1:0])
BR_OPCODE, 4'hC, conditional PC-relative branch opcode (Instr[15:12])
JMP_OPCODE, 4'hD, absolute jump-to-register opcode
HALT_OPCODE, 4'hF, halt opcode

Ports:
Clock  in  1  system clock, all state on rising edge
Reset  in  1  synchronous, active-high reset
PcValue  in  16  current program counter value
LoadValue  out  16  absolute PC load value
LoadEnable  out  1  PC load strobe
Offset  out  9  two's-complement PC offset
OffsetEnable  out  1  PC offset-add strobe
PcHold  out  1  1 = PC must keep its value this cycle
MemReq  out  1  instruction memory request
MemAddr  out  16  request address (= PcValue)
MemAck  in  1  memory returns MemData this cycle
MemData  in  16  fetched instruction
InstrValid  out  1  Instr valid to decode
Instr  out  16  latched instruction
InstrReady  in  1  decode accepts Instr
Flag  in  1  branch condition, sampled at the issue handshake
JumpTarget  in  16  register value for JMP, sampled at the issue handshake

Behaviour:
- States: IDLE, FETCH, ISSUE, ADVANCE, HALTED.
- Reset (sync) forces IDLE. It also zeroes Instr, LoadValue and Offset, and clears InstrValid, LoadEnable and OffsetEnable. MemReq=0, PcHold=1.
- IDLE -> FETCH unconditionally on the next cycle.
- FETCH: MemReq=1. MemAddr=PcValue (combinational, stable because PcHold=1). MemAck=1 -> latch MemData into Instr and go to ISSUE. Ack in the first FETCH cycle is legal (min latency: req cycle N, InstrValid at N+1).
- MemAck is ignored outside FETCH (late acks after reset are dropped).
- ISSUE: InstrValid=1, MemReq=0. Instr holds stable until InstrValid && InstrReady. On that handshake, go to ADVANCE and register the PC controls:
  - opcode == BR_OPCODE and Flag=1: OffsetEnable=1, Offset=Instr[8:0].
  - opcode == JMP_OPCODE: LoadEnable=1, LoadValue=JumpTarget.
  - opcode == HALT_OPCODE: go to HALTED instead of ADVANCE; no PC change.
  - otherwise (including BR with Flag=0): both enables 0, so the PC increments.
- InstrValid drops the cycle after the handshake.
- ADVANCE (exactly 1 cycle): PcHold=0; the PC updates at the end of this cycle. At most one of LoadEnable/OffsetEnable is 1. Next state is FETCH; enables return to 0.
- PcHold=1 in every state except ADVANCE.
- Offset is signed: the PC sign-extends it to 16 bits and adds it to the address of the branch instruction, modulo 2^16 (0x0002 + (-4) = 0xFFFE).
- HALTED: MemReq=0, InstrValid=0, PcHold=1. The block stays here until Reset.
- Reset has priority over every other event, including an in-flight request or a pending handshake.

Test Plan:
- ALU step: Reset, PcValue=0x0000, MemAck 2 cycles after MemReq rises with MemData=0x1234, InstrReady=1 -> InstrValid with Instr=0x1234. One ADVANCE cycle follows with PcHold=0 and both enables 0, then MemReq=1 again.
- Taken branch: Instr=0xC1FC, Flag=1 at handshake -> ADVANCE cycle with OffsetEnable=1, Offset=9'h1FC (-4), LoadEnable=0.
- Not-taken branch: Instr=0xC1FC, Flag=0 -> ADVANCE with both enables 0, PcHold=0 for exactly one cycle.
- Jump: Instr=0xD000, JumpTarget=0xBEEF -> ADVANCE with LoadEnable=1, LoadValue=0xBEEF. Next FETCH shows MemAddr=0xBEEF once the PC has loaded.
- Backpressure: InstrReady=0 for 5 cycles in ISSUE -> InstrValid=1 and Instr stable throughout, MemReq=0, PcHold=1. Advances only after InstrReady=1.
- Reset mid-fetch / halt:
  - Reset during FETCH with MemAck arriving the cycle after Reset -> ack ignored, block in IDLE then FETCH.
  - Instr=0xF000 accepted -> HALTED; no MemReq for 20 cycles, PcHold=1.
